// File: rtl/urisc_pkg.sv
// Shared URISC definitions: program-counter operation codes and the request priority encoder.
package urisc_pkg;

   typedef enum logic [2:0] {
      OP_HOLD = 3'd0,
      OP_INC  = 3'd1,
      OP_LOAD = 3'd2,
      OP_CALL = 3'd3,
      OP_RET  = 3'd4
   } pc_op_e;

   // Fixed priority ret > call > load > inc > hold; losing requests are dropped.
   function automatic pc_op_e pc_op_decode(input logic ret, input logic call,
                                           input logic load, input logic inc);
      pc_op_e op;
      if (ret)
         op = OP_RET;
      else if (call)
         op = OP_CALL;
      else if (load)
         op = OP_LOAD;
      else if (inc)
         op = OP_INC;
      else
         op = OP_HOLD;
      return op;
   endfunction

endpackage

// File: rtl/pc_stack_register_lifo.sv
// Bounded return-address LIFO: storage, depth counter, registered full/empty status.
module lifo_stack #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             push_data,
   output logic [WIDTH-1:0]             top_data_c,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         empty,
   output logic                         full
);

   localparam int unsigned DW = $clog2(DEPTH + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DW-1:0]    depth_next;
   logic             do_push;
   logic             do_pop;

   // Pop wins over push; requests against a full/empty stack are ignored.
   always_comb begin
      do_pop     = pop && !empty;
      do_push    = push && !full && !pop;
      depth_next = depth;
      if (do_pop)
         depth_next = depth - DW'(1);
      else if (do_push)
         depth_next = depth + DW'(1);
   end

   // Status flags are registered alongside the depth so all three move together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         depth <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else begin
         depth <= depth_next;
         empty <= (depth_next == '0);
         full  <= (depth_next == DW'(DEPTH));
      end
   end

   // Storage is deliberately not reset; entries above depth are never observable.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[AW'(depth)] <= push_data;
   end

   always_comb begin
      top_data_c = '0;
      if (!empty)
         top_data_c = mem[AW'(depth - DW'(1))];
   end

endmodule

// File: rtl/pc_stack_register.sv
// URISC program counter with step increment, branch load and a call/return address stack.
module pc_stack_register
   import urisc_pkg::*;
#(
   parameter int unsigned      WIDTH    = 16,
   parameter int unsigned      STEP     = 3,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         load,
   input  logic                         inc,
   input  logic                         call,
   input  logic                         ret,
   input  logic                         clr_err,
   input  logic [WIDTH-1:0]             data_in,
   output logic [WIDTH-1:0]             pc_out,
   output logic [$clog2(DEPTH+1)-1:0]   stack_depth,
   output logic                         stack_empty,
   output logic                         stack_full,
   output logic                         err_overflow,
   output logic                         err_underflow
);

   pc_op_e           op;
   logic [WIDTH-1:0] pc_step;
   logic [WIDTH-1:0] pc_next;
   logic [WIDTH-1:0] top_data;
   logic             push;
   logic             pop;
   logic             ovf_next;
   logic             unf_next;

   assign op      = pc_op_decode(ret, call, load, inc);
   assign pc_step = pc_out + WIDTH'(STEP);

   lifo_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .push_data  (pc_step),
      .top_data_c (top_data),
      .depth      (stack_depth),
      .empty      (stack_empty),
      .full       (stack_full)
   );

   // Op execution; a blocked call/ret leaves the PC alone and raises its sticky flag.
   always_comb begin
      pc_next  = pc_out;
      push     = 1'b0;
      pop      = 1'b0;
      ovf_next = clr_err ? 1'b0 : err_overflow;
      unf_next = clr_err ? 1'b0 : err_underflow;
      case (op)
         OP_INC:  pc_next = pc_step;
         OP_LOAD: pc_next = data_in;
         OP_CALL: begin
            if (stack_full) begin
               ovf_next = 1'b1;
            end else begin
               push    = 1'b1;
               pc_next = data_in;
            end
         end
         OP_RET: begin
            if (stack_empty) begin
               unf_next = 1'b1;
            end else begin
               pop     = 1'b1;
               pc_next = top_data;
            end
         end
         default: pc_next = pc_out;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_out        <= RESET_PC;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         pc_out        <= pc_next;
         err_overflow  <= ovf_next;
         err_underflow <= unf_next;
      end
   end

endmodule
